// File: rtl/adler32_engine.sv
// Streaming Adler-32 engine: length-prefixed byte stream in, {B,A} checksum out.
// Latency 1 clock after the last byte; no backpressure, one byte per data_start strobe.
module adler32_engine (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        size_valid,
  input  logic [31:0] size,
  input  logic        data_start,
  input  logic [7:0]  data,
  output logic        checksum_valid,
  output logic [31:0] checksum
);

  localparam logic [0:0]  IDLE = 1'b0;
  localparam logic [0:0]  BUSY = 1'b1;
  localparam logic [16:0] MOD  = 17'd65521;

  logic [0:0]  state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] remaining;

  logic [15:0] a_base;
  logic [15:0] b_base;
  logic [16:0] a_sum;
  logic [16:0] a_red;
  logic [15:0] a_next;
  logic [16:0] b_sum;
  logic [16:0] b_red;
  logic [15:0] b_next;

  // A new message seeds the accumulators, so a byte arriving with size_valid
  // is folded into the fresh A=1/B=0 state rather than the old message.
  always_comb begin
    a_base = size_valid ? 16'd1 : a_q;
    b_base = size_valid ? 16'd0 : b_q;
    a_sum  = {1'b0, a_base} + {9'd0, data};
    a_red  = a_sum - MOD;
    a_next = (a_sum >= MOD) ? a_red[15:0] : a_sum[15:0];
    b_sum  = {1'b0, b_base} + {1'b0, a_next};
    b_red  = b_sum - MOD;
    b_next = (b_sum >= MOD) ? b_red[15:0] : b_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state          <= IDLE;
      a_q            <= 16'd1;
      b_q            <= 16'd0;
      remaining      <= 32'd0;
      checksum_valid <= 1'b0;
      checksum       <= 32'h0;
    end else begin
      checksum_valid <= 1'b0;
      if (size_valid) begin
        if (size == 32'd0) begin
          // Empty message: checksum of nothing is A=1, B=0; any byte is ignored.
          state          <= IDLE;
          a_q            <= 16'd1;
          b_q            <= 16'd0;
          remaining      <= 32'd0;
          checksum_valid <= 1'b1;
          checksum       <= 32'h0000_0001;
        end else if (data_start) begin
          a_q <= a_next;
          b_q <= b_next;
          if (size == 32'd1) begin
            state          <= IDLE;
            remaining      <= 32'd0;
            checksum_valid <= 1'b1;
            checksum       <= {b_next, a_next};
          end else begin
            state     <= BUSY;
            remaining <= size - 32'd1;
          end
        end else begin
          state     <= BUSY;
          a_q       <= 16'd1;
          b_q       <= 16'd0;
          remaining <= size;
        end
      end else if (state == BUSY && data_start) begin
        a_q       <= a_next;
        b_q       <= b_next;
        remaining <= remaining - 32'd1;
        if (remaining == 32'd1) begin
          state          <= IDLE;
          checksum_valid <= 1'b1;
          checksum       <= {b_next, a_next};
        end
      end
    end
  end

endmodule

// File: tb/tb_adler32_engine.sv
// Directed bench for adler32_engine: table of messages with known checksums
// plus hand-written sequences for abort, reset, wrap and same-cycle start.
module tb_adler32_engine;

  logic        clock;
  logic        rst_n;
  logic        size_valid;
  logic [31:0] size;
  logic        data_start;
  logic [7:0]  data;
  logic        checksum_valid;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  adler32_engine dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .size_valid     (size_valid),
    .size           (size),
    .data_start     (data_start),
    .data           (data),
    .checksum_valid (checksum_valid),
    .checksum       (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (checksum_valid === 1'b1) pulses++;

  typedef struct {
    logic [31:0]    len;
    logic [8*16-1:0] msg;
    int             gap_max;
    logic [31:0]    exp;
  } vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_start = 1'b1;
    data       = b;
    step();
    data_start = 1'b0;
  endtask

  task automatic start_msg(input logic [31:0] n);
    size_valid = 1'b1;
    size       = n;
    step();
    size_valid = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int p0;
    logic [31:0] ma, mb, exp_big;

    vecs[0] = '{32'd5, "Hello",     0, 32'h058C01F5};
    vecs[1] = '{32'd9, "Wikipedia", 3, 32'h11E60398};
    vecs[2] = '{32'd0, 128'd0,      0, 32'h00000001};
    vecs[3] = '{32'd1, 128'hFF,     0, 32'h01000100};
    vecs[4] = '{32'd3, "abc",       2, 32'h024D0127};

    rst_n = 1'b0; size_valid = 1'b0; size = 32'd0; data_start = 1'b0; data = 8'd0;
    step(); step();
    check("reset_valid", {31'd0, checksum_valid}, 32'd0);
    check("reset_checksum", checksum, 32'h0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      p0 = pulses;
      start_msg(vecs[v].len);
      if (vecs[v].len != 0) begin
        for (int i = 0; i < int'(vecs[v].len); i++) begin
          int g;
          g = $urandom_range(0, vecs[v].gap_max);
          for (int k = 0; k < g; k++) step();
          if (i == int'(vecs[v].len) - 1)
            check($sformatf("v%0d_no_early", v), {31'd0, checksum_valid}, 32'd0);
          send_byte(vecs[v].msg[8*(int'(vecs[v].len)-1-i) +: 8]);
        end
      end
      check($sformatf("v%0d_valid", v), {31'd0, checksum_valid}, 32'd1);
      check($sformatf("v%0d_checksum", v), checksum, vecs[v].exp);
      step();
      check($sformatf("v%0d_valid_drop", v), {31'd0, checksum_valid}, 32'd0);
      check($sformatf("v%0d_hold", v), checksum, vecs[v].exp);
      check($sformatf("v%0d_pulses", v), pulses - p0, 32'd1);
    end

    // Long all-0xFF message forces both accumulators through the modulus.
    ma = 32'd1; mb = 32'd0;
    for (int i = 0; i < 5552; i++) begin
      ma = (ma + 32'd255) % 32'd65521;
      mb = (mb + ma) % 32'd65521;
    end
    exp_big = {mb[15:0], ma[15:0]};
    p0 = pulses;
    start_msg(32'd5552);
    for (int i = 0; i < 5552; i++) send_byte(8'hFF);
    check("big_valid", {31'd0, checksum_valid}, 32'd1);
    check("big_checksum", checksum, exp_big);
    step();
    check("big_pulses", pulses - p0, 32'd1);

    // Restart while busy: only the second message reports.
    p0 = pulses;
    start_msg(32'd10);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    start_msg(32'd5);
    send_byte("H"); send_byte("e"); send_byte("l"); send_byte("l"); send_byte("o");
    check("abort_checksum", checksum, 32'h058C01F5);
    step();
    check("abort_pulses", pulses - p0, 32'd1);

    // Reset mid-message: no pulse, outputs cleared, stray bytes ignored in IDLE.
    p0 = pulses;
    start_msg(32'd10);
    for (int i = 0; i < 3; i++) send_byte(8'h22);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_checksum", checksum, 32'h0);
    check("rst_mid_valid", {31'd0, checksum_valid}, 32'd0);
    for (int i = 0; i < 12; i++) send_byte(8'h33);
    step();
    check("rst_mid_pulses", pulses - p0, 32'd0);
    check("idle_bytes_checksum", checksum, 32'h0);

    // Byte on the same cycle as size_valid is the first byte of the message.
    p0 = pulses;
    size_valid = 1'b1; size = 32'd1; data_start = 1'b1; data = 8'h61;
    step();
    size_valid = 1'b0; data_start = 1'b0;
    check("same_cycle_valid", {31'd0, checksum_valid}, 32'd1);
    check("same_cycle_checksum", checksum, 32'h00620062);

    size_valid = 1'b1; size = 32'd3; data_start = 1'b1; data = 8'h61;
    step();
    size_valid = 1'b0; data_start = 1'b0;
    send_byte(8'h62);
    step();
    send_byte(8'h63);
    check("same_cycle_abc", checksum, 32'h024D0127);

    size_valid = 1'b1; size = 32'd0; data_start = 1'b1; data = 8'h61;
    step();
    size_valid = 1'b0; data_start = 1'b0;
    check("same_cycle_zero", checksum, 32'h00000001);
    step();
    check("same_cycle_pulses", pulses - p0, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
